incr_pack: RTL

//   Downstream consumer of the 4-bit incrementer stage. Collects consecutive

---
 rtl/incr_pkg.sv | 20 ++
 rtl/incr_pack_fifo.sv | 99 +++++++++
 rtl/incr_pack.sv | 112 +++++++++++
 3 files changed

// File: rtl/incr_pkg.sv
// Shared definitions for the 4-bit incrementer stage and its downstream
// packer: nibble width/type and the default packing geometry.
package incr_pkg;

    // Width of one incrementer result.
    localparam int NIB_W = 4;

    typedef logic [NIB_W-1:0] nib_t;

    // Default geometry shared by the incrementer stage and the packer.
    localparam int NIBBLES_DEF = 4;
    localparam int DEPTH_DEF   = 2;
    localparam int CNT_W_DEF   = 8;

    // Width of a packed word holding n nibbles.
    function automatic int word_width(input int n);
        return NIB_W * n;
    endfunction

endpackage

// File: rtl/incr_pack_fifo.sv
// Small synchronous FIFO for completed words. It owns the storage, the
// read/write pointers and the occupancy count.
//
// Handshake: the output side is strict valid/ready. A word transfers on every
// rising edge where pop_valid_o and pop_ready_i are both high; pop_valid_o
// never depends combinationally on pop_ready_i, and the head stays stable
// while pop_valid_o is high and pop_ready_i is low.
// The input side has no backpressure. push_i is a request, and push_ok_o says
// in the same cycle whether the word is taken (not full, or full with a
// concurrent pop freeing the head slot).
module incr_pack_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic                     push_ok_o,
    output logic                     pop_valid_o,
    output logic [WIDTH-1:0]         pop_data_o,
    input  logic                     pop_ready_i,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FILL_W-1:0] fill_q;

    logic empty;
    logic full;
    logic pop;
    logic push_ok;

    // Full/empty come from the occupancy count; pointers just wrap.
    always_comb begin
        empty   = (fill_q == '0);
        full    = (fill_q == FILL_W'(DEPTH));
        pop     = ~empty & pop_ready_i;
        // When full, the write slot equals the head slot being popped, so the
        // head word is read out before the new word overwrites it.
        push_ok = push_i & (~full | pop);
    end

    // Storage write; contents are cleared on reset so the head reads 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Write pointer advances on every accepted push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
        end else if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
    end

    // Read pointer advances on every pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
        end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Occupancy: push alone grows, pop alone shrinks, both together hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Head word is forced to 0 while empty so it is clean after reset.
    always_comb begin
        push_ok_o   = push_ok;
        pop_valid_o = ~empty;
        pop_data_o  = empty ? '0 : mem_q[rd_ptr_q];
        fill_o      = fill_q;
    end

endmodule

// File: rtl/incr_pack.sv
// Packs consecutive incrementer results into NIBBLES-wide words, first nibble
// in the least significant position, and hands finished words to a small
// output FIFO. Words that finish while the FIFO cannot take them are dropped
// and counted in a saturating counter.
module incr_pack
    import incr_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          nib_valid_i,
    input  nib_t                          nib_i,
    input  logic                          flush_i,
    output logic                          word_valid_o,
    output logic [NIB_W*NIBBLES-1:0]      word_o,
    input  logic                          word_ready_i,
    output logic [$clog2(DEPTH):0]        fill_o,
    output logic [CNT_W-1:0]              drop_cnt_o
);

    localparam int IDX_W  = $clog2(NIBBLES);
    localparam int WORD_W = word_width(NIBBLES);
    localparam int PART_N = NIBBLES - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [IDX_W-1:0]  idx_q;
    // Only the first NIBBLES-1 nibbles need storage; the last one goes
    // straight from nib_i into the pushed word.
    nib_t              asm_q [PART_N];
    logic [CNT_W-1:0]  drop_q;

    logic              accept;
    logic              complete;
    logic [WORD_W-1:0] push_word;
    logic              push_ok;

    // Flush wins over a nibble presented in the same cycle.
    always_comb begin
        accept   = nib_valid_i & ~flush_i;
        complete = accept & (idx_q == LAST_IDX);
    end

    // Nibble index: step on each accepted nibble, wrap after the last slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else if (flush_i) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= complete ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Assembly register: store each non-final nibble in its slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PART_N; i++) begin
                asm_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < PART_N; i++) begin
                asm_q[i] <= '0;
            end
        end else if (accept && !complete) begin
            for (int i = 0; i < PART_N; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    asm_q[i] <= nib_i;
                end
            end
        end
    end

    // Completed word: stored nibbles below, the live final nibble on top.
    always_comb begin
        push_word = '0;
        for (int i = 0; i < PART_N; i++) begin
            push_word[i*NIB_W +: NIB_W] = asm_q[i];
        end
        push_word[WORD_W-1 -: NIB_W] = nib_i;
    end

    // Drop counter: a completed word the FIFO refused, saturating at max.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else if (complete && !push_ok && (drop_q != CNT_MAX)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign drop_cnt_o = drop_q;

    incr_pack_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (complete),
        .push_data_i (push_word),
        .push_ok_o   (push_ok),
        .pop_valid_o (word_valid_o),
        .pop_data_o  (word_o),
        .pop_ready_i (word_ready_i),
        .fill_o      (fill_o)
    );

endmodule
